program_counter: RTL and testbench

- Registered program counter for the CPU datapath. Holds the address of the next instruction.
- Each rising clock edge it does one of three things: loads a jump target, increments, or holds.
- Asynchronous active-low reset forces the counter to its start address.
- Its output drives instruction-memory addressing directly.

---
 rtl/pc_pkg.sv | 6 +
 rtl/pc_incrementer.sv | 14 +
 rtl/program_counter.sv | 44 ++++
 tb/tb_program_counter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared widths, reset address and address type for the program counter slice.
package pc_pkg;
  localparam int unsigned PC_WIDTH = 16;
  localparam logic [PC_WIDTH-1:0] PC_RESET = 16'h0000;
  typedef logic [PC_WIDTH-1:0] pc_t;
endpackage

// File: rtl/pc_incrementer.sv
// Combinational step adder for the program counter; carry-out is dropped so the sum wraps.
module pc_incrementer
  import pc_pkg::*;
#(
  parameter int unsigned WIDTH = PC_WIDTH,
  parameter int unsigned STEP  = 1
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] sum
);
  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  assign sum = a + STEP_W;
endmodule

// File: rtl/program_counter.sv
// Registered program counter: load > increment > hold, async active-low reset to RESET_VALUE.
module program_counter
  import pc_pkg::*;
#(
  parameter int unsigned      WIDTH       = PC_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = PC_RESET,
  parameter int unsigned      STEP        = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_in,
  input  logic             load,
  input  logic             inc,
  output logic [WIDTH-1:0] d_out
);
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] pc_d;
  logic [WIDTH-1:0] pc_inc;

  pc_incrementer #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_inc (
    .a   (pc_q),
    .sum (pc_inc)
  );

  always_comb begin
    pc_d = pc_q;
    if (load)
      pc_d = d_in;
    else if (inc)
      pc_d = pc_inc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      pc_q <= RESET_VALUE;
    else
      pc_q <= pc_d;
  end

  assign d_out = pc_q;
endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: expected addresses are queued as stimulus is driven.
module tb_program_counter;
  import pc_pkg::*;

  logic clk;
  logic reset;
  pc_t  d_in;
  logic load;
  logic inc;
  pc_t  d_out;

  pc_t  sb[$];
  pc_t  exp_v;
  int   n_checks = 0;
  int   n_fail   = 0;

  program_counter #(
    .WIDTH       (16),
    .RESET_VALUE (16'h0000),
    .STEP        (1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .d_in  (d_in),
    .load  (load),
    .inc   (inc),
    .d_out (d_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk)
    if (reset === 1'b1)
      assert (!$isunknown({load, inc}))
      else $error("FAIL x_ctrl: load/inc unknown outside reset");

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of stimulus on the falling edge, queue the expected value, sample after the rising edge.
  task automatic apply(input logic rst, input logic ld, input logic in_c, input pc_t din, input pc_t e);
    @(negedge clk);
    reset = rst;
    load  = ld;
    inc   = in_c;
    d_in  = din;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    #1;
    n_checks++;
    if (d_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: d_out=%h expected=%h", d_out, 16'h0000);
    end
    apply(1'b0, 1'b1, 1'b1, 16'h003F, 16'h0000);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL reset_hold: d_out=%h expected=%h", d_out, exp_v);
    end
    for (int i = 1; i <= 3; i++) begin
      apply(1'b1, 1'b0, 1'b1, 16'h003F, pc_t'(i));
      exp_v = sb.pop_front();
      n_checks++;
      if (d_out !== exp_v) begin
        n_fail++;
        $display("FAIL reset_inc[%0d]: d_out=%h expected=%h", i, d_out, exp_v);
      end
    end
  endtask

  task automatic test_load;
    apply(1'b1, 1'b1, 1'b0, 16'h003F, 16'h003F);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL load: d_out=%h expected=%h", d_out, exp_v);
    end
    apply(1'b1, 1'b1, 1'b1, 16'h0003, 16'h0003);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL load_priority: d_out=%h expected=%h", d_out, exp_v);
    end
  endtask

  task automatic test_hold;
    apply(1'b1, 1'b1, 1'b0, 16'h0041, 16'h0041);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL hold_load: d_out=%h expected=%h", d_out, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1'b1, 1'b0, 1'b0, 16'hA5A5, 16'h0041);
      exp_v = sb.pop_front();
      n_checks++;
      if (d_out !== exp_v) begin
        n_fail++;
        $display("FAIL hold[%0d]: d_out=%h expected=%h", i, d_out, exp_v);
      end
    end
  endtask

  task automatic test_wrap;
    apply(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF);
    apply(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0000);
    apply(1'b1, 1'b0, 1'b1, 16'h1234, 16'h0001);
    for (int i = 0; i < 3; i++) begin
      exp_v = sb.pop_front();
      n_checks++;
      if (d_out !== exp_v && sb.size() == 0) begin
        n_fail++;
        $display("FAIL wrap_final: d_out=%h expected=%h", d_out, exp_v);
      end
    end
  endtask

  task automatic test_async_reset;
    apply(1'b1, 1'b1, 1'b0, 16'h0004, 16'h0004);
    exp_v = sb.pop_front();
    apply(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0005);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL count5: d_out=%h expected=%h", d_out, exp_v);
    end
    apply(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0006);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL count6: d_out=%h expected=%h", d_out, exp_v);
    end
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if (d_out !== 16'h0000) begin
      n_fail++;
      $display("FAIL async_mid: d_out=%h expected=%h", d_out, 16'h0000);
    end
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000);
      exp_v = sb.pop_front();
      n_checks++;
      if (d_out !== exp_v) begin
        n_fail++;
        $display("FAIL async_hold[%0d]: d_out=%h expected=%h", i, d_out, exp_v);
      end
    end
    apply(1'b1, 1'b0, 1'b1, 16'h0000, 16'h0001);
    exp_v = sb.pop_front();
    n_checks++;
    if (d_out !== exp_v) begin
      n_fail++;
      $display("FAIL async_release: d_out=%h expected=%h", d_out, exp_v);
    end
  endtask

  task automatic test_wrap_steps;
    apply(1'b1, 1'b1, 1'b0, 16'hFFFE, 16'hFFFE);
    for (int i = 0; i < 3; i++)
      apply(1'b1, 1'b0, 1'b1, 16'h0000, pc_t'(16'hFFFF + i));
    for (int i = 0; i < 4; i++) begin
      exp_v = sb.pop_front();
      if (i == 3) begin
        n_checks++;
        if (d_out !== exp_v) begin
          n_fail++;
          $display("FAIL wrap_steps: d_out=%h expected=%h", d_out, exp_v);
        end
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    load  = 1'b0;
    inc   = 1'b0;
    d_in  = '0;
    test_reset();
    test_load();
    test_hold();
    test_wrap();
    test_async_reset();
    test_wrap_steps();
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: remaining=%0d expected=%0d", sb.size(), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
